cond_logic: RTL
===============

Name: cond_logic

Overview:
- Consumer end of the ALU flag interface. Holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field against it.
- Gates the write-enables of the single-cycle datapath (PC, register file, memory), updates flags selectively from ALUFlags, and keeps saturating executed/squashed instruction counters for debug.
- Sits between the decoder/ALU and the PC, register-file and data-memory write ports.

Parameters:
- CNT_W, 16, width of each performance counter (minimum 2)

Ports:
- CLK  in  1  system clock, rising edge
- RESET_n  in  1  asynchronous, active-low reset
- Valid  in  1  current instruction is valid
- Stall  in  1  hold: suppress all writes and all state updates this cycle
- Cond  in  4  instruction condition field, bits [31:28]
- ALUFlags  in  4  {N,Z,C,V} from ALU for current instruction
- FlagW  in  2  [1]: update N,Z; [0]: update C,V
- PCS  in  1  instruction writes PC
- RegW  in  1  instruction writes register file
- MemW  in  1  instruction writes memory
- NoWrite  in  1  compare-class op, suppresses RegWrite
- ClrCount  in  1  synchronous clear of both counters
- PCSrc  out  1  gated PC write
- RegWrite  out  1  gated register write
- MemWrite  out  1  gated memory write
- CondEx  out  1  condition passed, combinational
- Flags  out  4  registered {N,Z,C,V}
- CarryIn  out  1  equals Flags[1], for ADC/SBC
- ExecCount  out  CNT_W  executed instructions
- SkipCount  out  CNT_W  condition-failed instructions

Behaviour:
- Reset (RESET_n=0, async): Flags=4'b0000, ExecCount=0, SkipCount=0. Combinational outputs follow from these values and the current inputs.
- CondEx is computed from the registered Flags, never from ALUFlags. It is combinational with 0-cycle latency.
- Condition table:
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 treated as AL (1)
- Define go = Valid & !Stall & CondEx.
- Write enables:
  - PCSrc = PCS & go
  - RegWrite = RegW & !NoWrite & go
  - MemWrite = MemW & go
- Flag update on the rising edge when go=1:
  - FlagW[1]=1: Flags[3:2] <= ALUFlags[3:2]
  - FlagW[0]=1: Flags[1:0] <= ALUFlags[1:0]
  - Unselected bits hold their value.
  - Updated flags are visible to the next instruction's CondEx, one cycle later.
- A condition-failed instruction never updates flags, even with FlagW!=0.
- Counters, evaluated on each rising edge:
  - ClrCount=1: both counters <= 0. This has priority over any increment in the same cycle, and applies even when Stall=1.
  - Otherwise, when Valid & !Stall: CondEx=1 increments ExecCount, CondEx=0 increments SkipCount.
  - Each counter saturates at all-ones and never wraps.
- Stall=1 forces PCSrc, RegWrite and MemWrite to 0 and freezes Flags and both counters; the only exception is ClrCount.
- Valid=0 behaves like Stall for flags, writes and counters; CondEx is still driven.
- Reset asserted mid-operation clears Flags and counters immediately, without waiting for CLK. Combinational outputs re-evaluate at once.

Test Plan:
- Reset, then Cond=0000 (EQ), Valid=1, PCS=1 -> CondEx=0, PCSrc=0, SkipCount=1, ExecCount=0.
- CMP: Cond=1110, FlagW=11, NoWrite=1, RegW=1, ALUFlags=0100 -> RegWrite=0; next cycle Flags=0100. Then Cond=0000, PCS=1 -> PCSrc=1, ExecCount=2.
- Partial update: Flags=1000, FlagW=01, ALUFlags=0111, Cond=AL -> Flags=1011, CarryIn=1. Then Cond=1010 (GE, N==V) -> CondEx=1. Cond=1000 (HI, C&!Z) -> CondEx=1.
- Failed condition with FlagW=11, ALUFlags=1111 and Stall=1 with AL, MemW=1 -> Flags unchanged and MemWrite=0 in both cases; counters unchanged under Stall.
- CNT_W=2: 5 valid AL instructions -> ExecCount holds 3. ClrCount together with a valid instruction -> ExecCount=0 next cycle.
- Drive RESET_n low between clock edges with Flags=1111 and counters nonzero -> all read 0 before the next edge. CondEx for GT becomes 1 (Z=0, N==V).

Source files
------------

// File: rtl/cond_logic.sv
// Condition-check unit: holds the NZCV flag register, evaluates the ARM condition
// field against it, gates datapath write-enables and keeps saturating debug counters.
module cond_logic #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             Valid,
    input  logic             Stall,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             ClrCount,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic             CarryIn,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    localparam logic [CNT_W-1:0] cnt_max = '1;
    localparam logic [CNT_W-1:0] cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0] flags_q;
    logic       n, z, c, v;
    logic       cond_ex;
    logic       go;
    logic       issue;
    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] skip_q;

    assign {n, z, c, v} = flags_q;

    // Condition is judged against the architectural flags, never the in-flight ALU flags.
    always_comb begin
        cond_ex = 1'b1;
        case (Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            default: cond_ex = 1'b1;
        endcase
    end

    assign issue = Valid & ~Stall;
    assign go    = issue & cond_ex;

    assign CondEx   = cond_ex;
    assign PCSrc    = PCS & go;
    assign RegWrite = RegW & ~NoWrite & go;
    assign MemWrite = MemW & go;
    assign Flags    = flags_q;
    assign CarryIn  = flags_q[1];
    assign ExecCount = exec_q;
    assign SkipCount = skip_q;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            flags_q <= 4'b0000;
        end else if (go) begin
            if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // Clear wins over increment and is honoured even while stalled.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            exec_q <= '0;
            skip_q <= '0;
        end else if (ClrCount) begin
            exec_q <= '0;
            skip_q <= '0;
        end else if (issue) begin
            if (cond_ex) begin
                if (exec_q != cnt_max) exec_q <= exec_q + cnt_one;
            end else begin
                if (skip_q != cnt_max) skip_q <= skip_q + cnt_one;
            end
        end
    end

endmodule
